usb_phy_filt: RTL

USB_PHY_FILT -- requirements
Module: usb_phy_filt

---
 rtl/usb_phy_filt.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/usb_phy_filt.sv
// USB full-speed pad front end: rx synchronisation with tx-echo masking, tx pad drive,
// and bus reset / suspend detection from the filtered line state.
module usb_phy_filt #(
    parameter int unsigned SYNC_STAGES    = 2,
    parameter int unsigned RESET_CYCLES   = 120,
    parameter int unsigned SUSPEND_CYCLES = 144000,
    parameter int unsigned TX_TURNAROUND  = 2,
    parameter int unsigned TX_REG         = 1
) (
    input  logic       clk_48mhz,
    input  logic       reset,
    input  logic       usb_p_tx,
    input  logic       usb_n_tx,
    input  logic       usb_tx_en,
    output logic       usb_p_rx,
    output logic       usb_n_rx,
    output logic       pad_p_out,
    output logic       pad_n_out,
    output logic       pad_oe,
    input  logic       pad_p_in,
    input  logic       pad_n_in,
    output logic       usb_reset,
    output logic       usb_suspend,
    output logic [1:0] line_state
);

    localparam int unsigned SE0_W = $clog2(RESET_CYCLES + 1);
    localparam int unsigned J_W   = $clog2(SUSPEND_CYCLES + 1);

    typedef enum logic [1:0] {
        ACTIVE,
        BUS_RESET,
        SUSPEND
    } state_t;

    logic [SYNC_STAGES-1:0] sync_p_q, sync_n_q;
    logic                   sync_p, sync_n;
    logic                   oe_q;
    logic                   oe_fall;
    logic [3:0]             ta_q, ta_eff;
    logic                   mask;
    logic                   is_se0, is_j;
    logic [SE0_W-1:0]       se0_q, se0_d;
    logic [J_W-1:0]         j_q, j_d;
    state_t                 state;

    // Idle is J, so the synchroniser powers up holding J rather than SE0.
    always_ff @(posedge clk_48mhz or posedge reset) begin
        if (reset) begin
            sync_p_q <= '1;
            sync_n_q <= '0;
        end else begin
            sync_p_q <= {sync_p_q[SYNC_STAGES-2:0], pad_p_in};
            sync_n_q <= {sync_n_q[SYNC_STAGES-2:0], pad_n_in};
        end
    end

    assign sync_p     = sync_p_q[SYNC_STAGES-1];
    assign sync_n     = sync_n_q[SYNC_STAGES-1];
    assign line_state = {sync_p, sync_n};

    generate
        if (TX_REG != 0) begin : g_tx_reg
            always_ff @(posedge clk_48mhz or posedge reset) begin
                if (reset) begin
                    pad_p_out <= 1'b0;
                    pad_n_out <= 1'b0;
                    pad_oe    <= 1'b0;
                end else begin
                    pad_p_out <= usb_p_tx;
                    pad_n_out <= usb_n_tx;
                    pad_oe    <= usb_tx_en;
                end
            end
        end else begin : g_tx_comb
            assign pad_p_out = usb_p_tx;
            assign pad_n_out = usb_n_tx;
            assign pad_oe    = usb_tx_en;
        end
    endgenerate

    // The falling cycle itself already sees the loaded count, so the mask has no gap.
    assign oe_fall = oe_q & ~pad_oe;
    assign ta_eff  = oe_fall ? 4'(TX_TURNAROUND) : ta_q;
    assign mask    = pad_oe | (ta_eff != 4'd0);

    always_ff @(posedge clk_48mhz or posedge reset) begin
        if (reset) begin
            oe_q <= 1'b0;
            ta_q <= 4'd0;
        end else begin
            oe_q <= pad_oe;
            ta_q <= (ta_eff != 4'd0) ? ta_eff - 4'd1 : 4'd0;
        end
    end

    assign usb_p_rx = mask | sync_p;
    assign usb_n_rx = ~mask & sync_n;

    assign is_se0 = (line_state == 2'b00);
    assign is_j   = (line_state == 2'b10);

    always_comb begin
        se0_d = se0_q;
        j_d   = j_q;
        if (!mask) begin
            if (is_se0) begin
                se0_d = (se0_q == SE0_W'(RESET_CYCLES)) ? se0_q : se0_q + SE0_W'(1);
            end else begin
                se0_d = '0;
            end
            if (is_j) begin
                j_d = (j_q == J_W'(SUSPEND_CYCLES)) ? j_q : j_q + J_W'(1);
            end else begin
                j_d = '0;
            end
        end
    end

    // Flags are registered copies of the state, one cycle behind each transition.
    always_ff @(posedge clk_48mhz or posedge reset) begin
        if (reset) begin
            state       <= ACTIVE;
            se0_q       <= '0;
            j_q         <= '0;
            usb_reset   <= 1'b0;
            usb_suspend <= 1'b0;
        end else begin
            se0_q       <= se0_d;
            j_q         <= j_d;
            usb_reset   <= (state == BUS_RESET);
            usb_suspend <= (state == SUSPEND);
            case (state)
                ACTIVE: begin
                    if (se0_d == SE0_W'(RESET_CYCLES)) begin
                        state <= BUS_RESET;
                    end else if (j_d == J_W'(SUSPEND_CYCLES)) begin
                        state <= SUSPEND;
                    end
                end
                BUS_RESET: begin
                    if (!mask && !is_se0) begin
                        state <= ACTIVE;
                    end
                end
                SUSPEND: begin
                    if (!mask && !is_j) begin
                        state <= ACTIVE;
                    end
                end
                default: state <= ACTIVE;
            endcase
        end
    end

endmodule
